sw_input_conditioner: RTL and testbench

- Conditioning stage directly upstream of the CPU's 10-bit SW bus.
- Feeds the 2x1 mux (SW[2:0]) and the full adder (SW[9:7]).
- Synchronises raw board switches to clk and debounces each bit independently.
- Presents a glitch-free sw_clean bus plus per-bit edge strobes and a settled flag.

---
 rtl/sw_cond_pkg.sv | 22 ++
 rtl/debounce_bit.sv | 84 ++++++++
 rtl/sw_input_conditioner.sv | 41 ++++
 tb/tb_sw_input_conditioner.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sw_cond_pkg.sv
// Shared constants and types for the switch input conditioner.
// Bit indices name the SW lines consumed by the mux and the full adder.
package sw_cond_pkg;

    localparam int WIDTH_DEF             = 10;
    localparam int SYNC_STAGES_DEF       = 2;
    localparam int DEBOUNCE_CYCLES_DEF   = 4;
    localparam int DEBOUNCE_CYCLES_BOARD = 500000;

    localparam int MUX_IN0 = 0;
    localparam int MUX_IN1 = 1;
    localparam int MUX_SEL = 2;
    localparam int FA_A    = 7;
    localparam int FA_B    = 8;
    localparam int FA_CIN  = 9;

    typedef enum logic {
        DB_IDLE,
        DB_COUNT
    } db_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchroniser chain, debounce counter/FSM and registered edge strobes.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
module debounce_bit
    import sw_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic settled
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync_bit;
    db_state_t              state;
    logic [CNT_W-1:0]       cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync_bit = sync_chain[SYNC_STAGES-1];

    // Strobes default low so each accept yields exactly one pulse cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DB_IDLE;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                DB_IDLE: begin
                    if (sync_bit != clean) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            clean <= sync_bit;
                            rise  <= sync_bit;
                            fall  <= ~sync_bit;
                        end else begin
                            state <= DB_COUNT;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                DB_COUNT: begin
                    if (sync_bit == clean) begin
                        state <= DB_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        clean <= sync_bit;
                        rise  <= sync_bit;
                        fall  <= ~sync_bit;
                        state <= DB_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= DB_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign settled = (cnt == '0) && (sync_bit == clean);

endmodule

// File: rtl/sw_input_conditioner.sv
// Conditions the raw board switches feeding the CPU SW bus: per-bit sync + debounce,
// with aggregated change strobe and an all-settled flag.
module sw_input_conditioner
    import sw_cond_pkg::*;
#(
    parameter int WIDTH           = WIDTH_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed,
    output logic             stable
);

    logic [WIDTH-1:0] settled;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .raw    (sw_raw[gi]),
            .clean  (sw_clean[gi]),
            .rise   (sw_rise[gi]),
            .fall   (sw_fall[gi]),
            .settled(settled[gi])
        );
    end

    // Both terms come straight from flops, so this pulse is aligned with the strobes.
    assign sw_changed = |(sw_rise | sw_fall);
    assign stable     = &settled;

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Self-checking bench: directed scenarios plus randomized toggling against a
// history-based reference model of the debounce rule.
module tb_sw_input_conditioner;
    import sw_cond_pkg::*;

    localparam int W  = 10;
    localparam int SS = 2;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw, sw_clean, sw_rise, sw_fall;
    logic         sw_changed, stable;
    logic [W-1:0] raw1, clean1, rise1, fall1;
    logic         changed1, stable1;

    int checks = 0;
    int errors = 0;

    // Reference model: a window of raw samples, one per clock edge.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_clean, m_rise, m_fall;
    logic         m_changed, m_stable;

    sw_input_conditioner #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw), .sw_clean(sw_clean),
        .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_changed(sw_changed), .stable(stable)
    );

    sw_input_conditioner #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .sw_raw(raw1), .sw_clean(clean1),
        .sw_rise(rise1), .sw_fall(fall1), .sw_changed(changed1), .stable(stable1)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        hist.delete();
        for (int j = 0; j < SS + DC; j++) hist.push_back('0);
        m_clean   = '0;
        m_rise    = '0;
        m_fall    = '0;
        m_changed = 1'b0;
        m_stable  = 1'b1;
    endtask

    // A bit flips once the last DC synchronised samples all disagree with its clean level.
    task automatic model_edge();
        logic [W-1:0] acc, pend, presync, sync_now, new_clean;
        int n;
        if (reset) begin
            model_clear();
            return;
        end
        hist.push_back(sw_raw);
        void'(hist.pop_front());
        n        = hist.size();
        presync  = hist[n-1-SS];
        sync_now = hist[n-SS];
        for (int i = 0; i < W; i++) begin
            acc[i] = 1'b1;
            for (int j = 0; j < DC; j++)
                if (hist[n-1-SS-j][i] == m_clean[i]) acc[i] = 1'b0;
        end
        pend      = (presync ^ m_clean) & ~acc;
        new_clean = m_clean ^ acc;
        m_rise    = acc & new_clean;
        m_fall    = acc & ~new_clean;
        m_changed = |acc;
        m_clean   = new_clean;
        m_stable  = (((sync_now ^ new_clean) | pend) == '0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [W-1:0] exp_v;
        sw_raw = '1;
        raw1   = '0;
        reset  = 1'b1;
        model_clear();
        repeat (2) tick();
        checks++; if (sw_clean !== '0) begin errors++; $display("FAIL reset_clean got %h want %h", sw_clean, 10'h000); end
        checks++; if (sw_rise !== '0) begin errors++; $display("FAIL reset_rise got %h want %h", sw_rise, 10'h000); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL reset_stable got %b want 1", stable); end
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_v = (e >= 6) ? '1 : '0;
            checks++; if (sw_clean !== exp_v) begin errors++; $display("FAIL rel_clean e%0d got %h want %h", e, sw_clean, exp_v); end
            exp_v = (e == 6) ? '1 : '0;
            checks++; if (sw_rise !== exp_v) begin errors++; $display("FAIL rel_rise e%0d got %h want %h", e, sw_rise, exp_v); end
            checks++; if (sw_changed !== (e == 6)) begin errors++; $display("FAIL rel_changed e%0d got %b want %b", e, sw_changed, e == 6); end
        end
    endtask

    task automatic test_step();
        logic [W-1:0] exp_v;
        sw_raw = '0;
        repeat (12) tick();
        checks++; if (sw_clean !== '0 || stable !== 1'b1) begin errors++; $display("FAIL step_pre got %h/%b want 000/1", sw_clean, stable); end
        sw_raw[MUX_SEL] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_v = (e >= 6) ? 10'h004 : 10'h000;
            checks++; if (sw_clean !== exp_v) begin errors++; $display("FAIL step_clean e%0d got %h want %h", e, sw_clean, exp_v); end
            exp_v = (e == 6) ? 10'h004 : 10'h000;
            checks++; if (sw_rise !== exp_v || sw_fall !== '0) begin errors++; $display("FAIL step_strobe e%0d got %h/%h want %h/000", e, sw_rise, sw_fall, exp_v); end
            checks++; if (stable !== !(e >= 2 && e <= 5)) begin errors++; $display("FAIL step_stable e%0d got %b want %b", e, stable, !(e >= 2 && e <= 5)); end
        end
    endtask

    task automatic test_bounce();
        logic [W-1:0] exp_v;
        for (int e = 1; e <= 12; e++) begin
            sw_raw[FA_A] = (e != 4);
            tick();
            exp_v = 10'h004 | ((e >= 10) ? 10'h080 : 10'h000);
            checks++; if (sw_clean !== exp_v) begin errors++; $display("FAIL bounce_clean e%0d got %h want %h", e, sw_clean, exp_v); end
            exp_v = (e == 10) ? 10'h080 : 10'h000;
            checks++; if (sw_rise !== exp_v) begin errors++; $display("FAIL bounce_rise e%0d got %h want %h", e, sw_rise, exp_v); end
        end
    endtask

    task automatic test_simultaneous();
        int pulses = 0;
        sw_raw[FA_CIN] = 1'b1;
        repeat (8) tick();
        checks++; if (sw_clean !== 10'h284) begin errors++; $display("FAIL simul_pre got %h want %h", sw_clean, 10'h284); end
        sw_raw[FA_B]   = 1'b1;
        sw_raw[FA_CIN] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (sw_changed === 1'b1) pulses++;
            if (e == 5) begin
                checks++; if (sw_clean !== 10'h284) begin errors++; $display("FAIL simul_e5 got %h want %h", sw_clean, 10'h284); end
            end
            if (e == 6) begin
                checks++; if (sw_clean !== 10'h184) begin errors++; $display("FAIL simul_clean got %h want %h", sw_clean, 10'h184); end
                checks++; if (sw_rise !== 10'h100 || sw_fall !== 10'h200) begin errors++; $display("FAIL simul_strobes got %h/%h want 100/200", sw_rise, sw_fall); end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL simul_changed_count got %0d want 1", pulses); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] exp_v;
        sw_raw[MUX_IN0] = 1'b1;
        repeat (4) tick();
        checks++; if (sw_clean[MUX_IN0] !== 1'b0) begin errors++; $display("FAIL mid_pre got %b want 0", sw_clean[MUX_IN0]); end
        reset = 1'b1;
        model_clear();
        #1;
        checks++; if (sw_clean !== '0) begin errors++; $display("FAIL mid_async got %h want %h", sw_clean, 10'h000); end
        repeat (2) tick();
        checks++; if (sw_clean !== '0) begin errors++; $display("FAIL mid_hold got %h want %h", sw_clean, 10'h000); end
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_v = (e >= 6) ? 10'h185 : 10'h000;
            checks++; if (sw_clean !== exp_v) begin errors++; $display("FAIL mid_clean e%0d got %h want %h", e, sw_clean, exp_v); end
            exp_v = (e == 6) ? 10'h185 : 10'h000;
            checks++; if (sw_rise !== exp_v) begin errors++; $display("FAIL mid_rise e%0d got %h want %h", e, sw_rise, exp_v); end
        end
    endtask

    task automatic test_dc1();
        logic [W-1:0] exp_v;
        raw1[MUX_IN1] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            exp_v = (e >= 3) ? 10'h002 : 10'h000;
            checks++; if (clean1 !== exp_v) begin errors++; $display("FAIL dc1_clean e%0d got %h want %h", e, clean1, exp_v); end
            exp_v = (e == 3) ? 10'h002 : 10'h000;
            checks++; if (rise1 !== exp_v || changed1 !== (e == 3)) begin errors++; $display("FAIL dc1_rise e%0d got %h/%b want %h", e, rise1, changed1, exp_v); end
        end
        raw1[MUX_IN1] = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            exp_v = (e >= 3) ? 10'h000 : 10'h002;
            checks++; if (clean1 !== exp_v) begin errors++; $display("FAIL dc1_fclean e%0d got %h want %h", e, clean1, exp_v); end
            exp_v = (e == 3) ? 10'h002 : 10'h000;
            checks++; if (fall1 !== exp_v) begin errors++; $display("FAIL dc1_fall e%0d got %h want %h", e, fall1, exp_v); end
        end
        checks++; if (stable1 !== 1'b1) begin errors++; $display("FAIL dc1_stable got %b want 1", stable1); end
    endtask

    task automatic test_random();
        logic [W-1:0] mask;
        for (int c = 0; c < 600; c++) begin
            mask = '0;
            for (int i = 0; i < W; i++)
                if ($urandom_range(11) == 0) mask[i] = 1'b1;
            sw_raw = sw_raw ^ mask;
            tick();
            checks++; if (sw_clean !== m_clean) begin errors++; $display("FAIL rnd_clean c%0d got %h want %h", c, sw_clean, m_clean); end
            checks++; if (sw_rise !== m_rise) begin errors++; $display("FAIL rnd_rise c%0d got %h want %h", c, sw_rise, m_rise); end
            checks++; if (sw_fall !== m_fall) begin errors++; $display("FAIL rnd_fall c%0d got %h want %h", c, sw_fall, m_fall); end
            checks++; if (sw_changed !== m_changed) begin errors++; $display("FAIL rnd_changed c%0d got %b want %b", c, sw_changed, m_changed); end
            checks++; if (stable !== m_stable) begin errors++; $display("FAIL rnd_stable c%0d got %b want %b", c, stable, m_stable); end
        end
    endtask

    initial begin
        reset  = 1'b1;
        sw_raw = '0;
        raw1   = '0;
        model_clear();
        test_reset();
        test_step();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_dc1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
